// File: rtl/lcd_object_writer_if.sv
// lcd_object_writer_if: HD44780 8-bit write bus.
// The writer drives it as master; the LCD or a bus monitor listens as slave.
interface lcd_object_writer_if;
  logic [7:0] lcd_data;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_en;

  modport master (
    output lcd_data,
    output lcd_rs,
    output lcd_rw,
    output lcd_en
  );

  modport slave (
    input lcd_data,
    input lcd_rs,
    input lcd_rw,
    input lcd_en
  );
endinterface

// File: rtl/lcd_object_writer.sv
// lcd_object_writer: multi-object sprite writer for 2x16 HD44780 LCDs.
// Each frame erases cells of moved objects, then redraws every visible glyph.
module lcd_object_writer #(
  parameter int         N_OBJ       = 2,
  parameter int         COLS        = 16,
  parameter int         POS_W       = 5,
  parameter int         EN_HIGH_CYC = 2,
  parameter int         WAIT_CYC    = 4,
  parameter logic [7:0] BLANK_CHAR  = 8'h20
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   next,
  input  logic [N_OBJ-1:0]       obj_valid,
  input  logic [N_OBJ-1:0]       obj_row,
  input  logic [N_OBJ*POS_W-1:0] obj_pos,
  input  logic [N_OBJ*8-1:0]     obj_glyph,
  output logic                   busy,
  output logic                   done,
  lcd_object_writer_if.master    lcd
);

  typedef enum logic [2:0] {
    IDLE,
    ERASE_SCAN,
    ERASE_ADDR,
    ERASE_DATA,
    DRAW_SCAN,
    DRAW_ADDR,
    DRAW_DATA,
    FINISH
  } state_t;

  localparam int TOT   = 1 + EN_HIGH_CYC + WAIT_CYC;
  localparam int CNT_W = $clog2(TOT + 1);
  localparam int IDX_W = (N_OBJ > 1) ? $clog2(N_OBJ) : 1;

  localparam logic [IDX_W-1:0] LAST   = IDX_W'(N_OBJ - 1);
  localparam logic [CNT_W-1:0] CNT_LS = CNT_W'(TOT - 1);
  localparam logic [CNT_W-1:0] CNT_EN = CNT_W'(EN_HIGH_CYC);
  localparam logic [POS_W:0]   COLS_L = (POS_W + 1)'(COLS);
  localparam logic [6:0]       COL_MX = 7'(COLS - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             en_q, en_d;
  logic             rs_q, rs_d;
  logic [7:0]       data_q, data_d;

  logic [N_OBJ-1:0] valid_q, valid_d;
  logic [N_OBJ-1:0] row_q, row_d;
  logic [POS_W-1:0] pos_q [N_OBJ];
  logic [POS_W-1:0] pos_d [N_OBJ];
  logic [7:0]       glyph_q [N_OBJ];
  logic [7:0]       glyph_d [N_OBJ];
  logic [N_OBJ-1:0] drawn_q, drawn_d;
  logic [6:0]       shadow_q [N_OBJ];
  logic [6:0]       shadow_d [N_OBJ];

  logic [N_OBJ-1:0] vis_c;
  logic [N_OBJ-1:0] erase_c;
  logic [6:0]       addr_c [N_OBJ];
  logic             in_txn;
  logic             txn_last;

  always_comb begin
    for (int i = 0; i < N_OBJ; i++) begin
      vis_c[i]   = valid_q[i] && ({1'b0, pos_q[i]} < COLS_L);
      addr_c[i]  = (row_q[i] ? 7'h40 : 7'h00)
                 + (COL_MX - 7'(pos_q[i]));
      erase_c[i] = drawn_q[i]
                 && (!vis_c[i] || (addr_c[i] != shadow_q[i]));
    end
  end

  assign in_txn = (state_q == ERASE_ADDR) || (state_q == ERASE_DATA)
               || (state_q == DRAW_ADDR)  || (state_q == DRAW_DATA);
  assign txn_last = (cnt_q == CNT_LS);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    en_d     = en_q;
    rs_d     = rs_q;
    data_d   = data_q;
    valid_d  = valid_q;
    row_d    = row_q;
    pos_d    = pos_q;
    glyph_d  = glyph_q;
    drawn_d  = drawn_q;
    shadow_d = shadow_q;

    if (in_txn && !txn_last) begin
      cnt_d = cnt_q + 1'b1;
      en_d  = (cnt_d <= CNT_EN);
    end else begin
      unique case (state_q)
        IDLE: begin
          // done_q blocks the cycle of the completion pulse itself
          if (next && !done_q) begin
            state_d = ERASE_SCAN;
            idx_d   = '0;
            busy_d  = 1'b1;
            valid_d = obj_valid;
            row_d   = obj_row;
            for (int i = 0; i < N_OBJ; i++) begin
              pos_d[i]   = obj_pos[i*POS_W +: POS_W];
              glyph_d[i] = obj_glyph[i*8 +: 8];
            end
          end
        end
        ERASE_SCAN, ERASE_DATA: begin
          if ((state_q == ERASE_SCAN) && erase_c[idx_q]) begin
            state_d = ERASE_ADDR;
            rs_d    = 1'b0;
            data_d  = {1'b1, shadow_q[idx_q]};
            cnt_d   = '0;
          end else if (idx_q == LAST) begin
            state_d = DRAW_SCAN;
            idx_d   = '0;
          end else begin
            state_d = ERASE_SCAN;
            idx_d   = idx_q + 1'b1;
          end
        end
        ERASE_ADDR: begin
          state_d = ERASE_DATA;
          rs_d    = 1'b1;
          data_d  = BLANK_CHAR;
          cnt_d   = '0;
        end
        DRAW_SCAN, DRAW_DATA: begin
          if ((state_q == DRAW_SCAN) && vis_c[idx_q]) begin
            state_d = DRAW_ADDR;
            rs_d    = 1'b0;
            data_d  = {1'b1, addr_c[idx_q]};
            cnt_d   = '0;
          end else if (idx_q == LAST) begin
            state_d = FINISH;
          end else begin
            state_d = DRAW_SCAN;
            idx_d   = idx_q + 1'b1;
          end
        end
        DRAW_ADDR: begin
          state_d = DRAW_DATA;
          rs_d    = 1'b1;
          data_d  = glyph_q[idx_q];
          cnt_d   = '0;
        end
        FINISH: begin
          state_d  = IDLE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          drawn_d  = vis_c;
          shadow_d = addr_c;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      en_q    <= 1'b0;
      rs_q    <= 1'b0;
      data_q  <= '0;
      valid_q <= '0;
      row_q   <= '0;
      drawn_q <= '0;
      for (int i = 0; i < N_OBJ; i++) begin
        pos_q[i]    <= '0;
        glyph_q[i]  <= '0;
        shadow_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      en_q     <= en_d;
      rs_q     <= rs_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      row_q    <= row_d;
      drawn_q  <= drawn_d;
      pos_q    <= pos_d;
      glyph_q  <= glyph_d;
      shadow_q <= shadow_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign lcd.lcd_data = data_q;
  assign lcd.lcd_rs   = rs_q;
  assign lcd.lcd_rw   = 1'b0;
  assign lcd.lcd_en   = en_q;

endmodule

// File: doc/lcd_object_writer.md
Name: lcd_object_writer

Overview:
- Multi-object character-LCD sprite writer for HD44780-style 2x16 displays.
- On each `next` frame request it erases the stale cells of moved objects, then draws the current glyph of every valid object.
- Drives the LCD 8-bit write bus with programmable enable-pulse and settle timing.
- Sits between game logic (object positions and glyphs) and the LCD pins; replaces the single-obstacle writer.

Parameters:
- N_OBJ, 2, number of object channels.
- COLS, 16, visible columns per row.
- POS_W, 5, position field width; pos >= COLS means off-screen.
- EN_HIGH_CYC, 2, clock cycles lcd_en stays high per transaction (>=1).
- WAIT_CYC, 4, clock cycles lcd_en stays low after each pulse before the next transaction (>=1).
- BLANK_CHAR, 8'h20, code written when erasing a cell.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- next  in  1  frame request pulse; sampled only in IDLE
- obj_valid  in  N_OBJ  object i is present this frame
- obj_row  in  N_OBJ  0 = row address 0x00, 1 = row address 0x40
- obj_pos  in  N_OBJ*POS_W  object i position, slice i; column = COLS-1-pos
- obj_glyph  in  N_OBJ*8  CGRAM/DDRAM character code for object i
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse at frame completion
- lcd_data  out  8  LCD data bus
- lcd_rs  out  1  0 = command, 1 = data
- lcd_rw  out  1  tied 0 (write only)
- lcd_en  out  1  LCD enable strobe

Behaviour:
- Reset (clk edge with rst=1): lcd_data=0, lcd_rs=0, lcd_rw=0, lcd_en=0, busy=0, done=0, FSM to IDLE, all drawn-shadow state cleared (no object considered on screen).
  - Reset mid-transaction aborts immediately; no completion pulse.
- Frame start (IDLE):
  - On next=1, snapshot obj_valid/row/pos/glyph into internal registers.
  - busy=1 from the following cycle.
  - Input changes during a frame are ignored.
  - next while busy is ignored (not queued).
- Visibility: object i is visible iff obj_valid[i]=1 and pos < COLS.
  - Cell address = (row ? 7'h40 : 7'h00) + (COLS-1-pos); command byte = 8'h80 | addr.
- FSM states: IDLE -> ERASE_SCAN -> (ERASE_ADDR -> ERASE_DATA)* -> DRAW_SCAN -> (DRAW_ADDR -> DRAW_DATA)* -> FINISH -> IDLE.
- ERASE phase, iterating i = 0..N_OBJ-1, one scan cycle per object:
  - Erase the shadow cell of object i if it was drawn last frame AND (it is not visible now OR its address changed).
  - Erase sequence: address command, then data BLANK_CHAR.
- DRAW phase, iterating i = 0..N_OBJ-1, one scan cycle per object:
  - For each visible object: address command, then data obj_glyph[i]. Glyphs are always rewritten, even if the position is unchanged (supports animation frames).
  - Update the shadow (drawn flag, address) at the end of the DRAW phase for every object; non-visible objects clear their drawn flag.
- All erases precede all draws, so an erase never clobbers a cell drawn this frame.
  - Two objects on the same cell: the higher index wins (drawn last).
- Bus transaction timing:
  - Setup cycle: lcd_rs/lcd_data driven, lcd_en=0.
  - Then lcd_en=1 for EN_HIGH_CYC cycles.
  - Then lcd_en=0 for WAIT_CYC cycles.
  - lcd_rs/lcd_data are held stable for the whole transaction. Total 1+EN_HIGH_CYC+WAIT_CYC cycles.
- FINISH: done=1 for exactly one cycle and busy=0 in that same cycle; return to IDLE. next is accepted again from the cycle after done.
- Frame with no transactions: busy high for 2*N_OBJ+1 cycles, then done.
- lcd_rw is never driven to 1.

Test Plan:
- Defaults (7 cycles/transaction).
  - After reset: obj0 valid, row0, pos=0, glyph=0x01; obj1 invalid; pulse next.
  - -> Bus sequence cmd 0x8F (rs=0), data 0x01 (rs=1); each en high exactly 2 cycles; done one pulse; no erase.
- Same frame, then obj0 pos=1, pulse next.
  - -> 0x8F/0x20 erase, then 0x8E/0x01 draw; 4 transactions total.
- Add obj1 valid, row1, pos=15, glyph=0x03 with obj0 unchanged.
  - -> No erase transactions; draws 0x8E/0x01 then 0xC0/0x03.
- obj0 pos=16 (off-screen), obj1 invalid, both previously drawn.
  - -> Erases 0x8E/0x20 and 0xC0/0x20, no draws; next frame with same inputs issues zero transactions and done within 2*N_OBJ+2 cycles.
- Both objects row0 pos=3, glyphs 0x01/0x02.
  - -> Draw order 0x8C/0x01 then 0x8C/0x02.
  - next re-pulsed while busy -> ignored; exactly one done.
- Assert rst during the en-high cycle of the 2nd transaction.
  - -> Next cycle all outputs 0, busy=0, no done.
  - Following frame performs no erases (shadow cleared).
